// File: rtl/brus16_pkg.sv
// rtl/brus16_pkg.sv - shared widths, rect table defaults and copy FSM states
package brus16_pkg;

  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_ADDR_WIDTH     = 13;
  localparam int DEF_BUF_ADDR_WIDTH = 9;
  localparam int DEF_RECT_COUNT     = 64;
  localparam int DEF_RECT_WORDS     = 5;
  localparam logic [12:0] DEF_RECT_BASE = 13'h1000;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } copy_state_t;

endpackage

// File: rtl/rect_copy_controller_if.sv
// rtl/rect_copy_controller_if.sv - copy handshake, data-memory read port and rect buffer write port
// RECT_COPY_CHECKSUM_EN adds the checksum signal.
interface rect_copy_controller_if
  import brus16_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int BUF_ADDR_WIDTH = DEF_BUF_ADDR_WIDTH
);

  logic                      copy_start;
  logic                      copy;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic                      mem_rd_en;
  logic [DATA_WIDTH-1:0]     mem_rd_data;
  logic                      buf_wr_en;
  logic [BUF_ADDR_WIDTH-1:0] buf_wr_addr;
  logic [DATA_WIDTH-1:0]     buf_wr_data;
  logic                      busy;
  logic                      done;
`ifdef RECT_COPY_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]     checksum;
`endif

  modport master (
`ifdef RECT_COPY_CHECKSUM_EN
    output checksum,
`endif
    input  copy_start, copy, mem_rd_data,
    output mem_addr, mem_rd_en, buf_wr_en, buf_wr_addr, buf_wr_data, busy, done
  );

  modport slave (
`ifdef RECT_COPY_CHECKSUM_EN
    input  checksum,
`endif
    output copy_start, copy, mem_rd_data,
    input  mem_addr, mem_rd_en, buf_wr_en, buf_wr_addr, buf_wr_data, busy, done
  );

endinterface

// File: rtl/copy_addr_counter.sv
// rtl/copy_addr_counter.sv - loadable, enable-gated index counter with terminal-count flag
module copy_addr_counter #(
  parameter int               WIDTH = 9,
  parameter logic [WIDTH-1:0] LAST  = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == LAST);

endmodule

// File: rtl/rect_copy_controller.sv
// rtl/rect_copy_controller.sv - streams the rect table from data memory into the GPU rect buffer
// RECT_COPY_CHECKSUM_EN adds a registered running sum of every written word.
module rect_copy_controller
  import brus16_pkg::*;
#(
  parameter int                    DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int                    ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int                    RECT_COUNT     = DEF_RECT_COUNT,
  parameter int                    RECT_WORDS     = DEF_RECT_WORDS,
  parameter logic [ADDR_WIDTH-1:0] RECT_BASE      = DEF_RECT_BASE,
  parameter int                    BUF_ADDR_WIDTH = DEF_BUF_ADDR_WIDTH
) (
  input logic                    clk,
  input logic                    reset,
  rect_copy_controller_if.master bus
);

  localparam int N = RECT_COUNT * RECT_WORDS;
  localparam logic [BUF_ADDR_WIDTH-1:0] LAST_IDX = BUF_ADDR_WIDTH'(N - 1);

  copy_state_t               state_q, state_d;
  logic                      rd_valid_q, rd_valid_d;
  logic                      start_accept;
  logic                      mem_rd_en;
  logic                      buf_wr_en;
  logic [BUF_ADDR_WIDTH-1:0] rd_idx, wr_idx;
  logic                      rd_last, wr_last;
  logic [DATA_WIDTH-1:0]     wr_data;

  copy_addr_counter #(.WIDTH(BUF_ADDR_WIDTH), .LAST(LAST_IDX)) u_rd_cnt (
    .clk       (clk),
    .reset     (reset),
    .load      (start_accept),
    .load_value('0),
    .en        (mem_rd_en),
    .count     (rd_idx),
    .tc        (rd_last)
  );

  copy_addr_counter #(.WIDTH(BUF_ADDR_WIDTH), .LAST(LAST_IDX)) u_wr_cnt (
    .clk       (clk),
    .reset     (reset),
    .load      (start_accept),
    .load_value('0),
    .en        (buf_wr_en),
    .count     (wr_idx),
    .tc        (wr_last)
  );

  // Losing ownership kills both the issuing read and the pending delayed write in the same cycle.
  always_comb begin
    start_accept = (state_q == IDLE) && bus.copy_start && bus.copy;
    mem_rd_en    = (state_q == READ) && bus.copy;
    buf_wr_en    = rd_valid_q && bus.copy;
    rd_valid_d   = mem_rd_en;
    wr_data      = buf_wr_en ? bus.mem_rd_data : '0;
    state_d      = state_q;
    case (state_q)
      IDLE: begin
        if (start_accept) state_d = READ;
      end
      READ: begin
        if (!bus.copy)   state_d = IDLE;
        else if (rd_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (!bus.copy)   state_d = IDLE;
        else if (wr_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.mem_rd_en   = mem_rd_en;
  assign bus.mem_addr    = mem_rd_en ? RECT_BASE + ADDR_WIDTH'(rd_idx) : '0;
  assign bus.buf_wr_en   = buf_wr_en;
  assign bus.buf_wr_addr = buf_wr_en ? wr_idx : '0;
  assign bus.buf_wr_data = wr_data;
  assign bus.busy        = (state_q == READ) || (state_q == DRAIN);
  assign bus.done        = (state_q == DONE);

`ifdef RECT_COPY_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

  // Published only on a completed copy so an abort leaves the last good value visible.
  always_comb begin
    sum_d = sum_q;
    if (start_accept) begin
      sum_d = '0;
    end else if (buf_wr_en) begin
      sum_d = sum_q + wr_data;
    end
    checksum_d = checksum_q;
    if ((state_q == DRAIN) && (state_d == DONE)) begin
      checksum_d = sum_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q      <= '0;
      checksum_q <= '0;
    end else begin
      sum_q      <= sum_d;
      checksum_q <= checksum_d;
    end
  end

  assign bus.checksum = checksum_q;
`endif

endmodule

// File: doc/rect_copy_controller.md
Name: rect_copy_controller

Overview:
- Responder to the frame controller's copy handshake.
- On a one-cycle `copy_start` pulse, streams the rectangle table from CPU data memory into the GPU rect buffer.
- Runs only while `copy` holds data-memory ownership, and reports completion with a one-cycle `done`.
- Sits between the data-memory port mux (copy side) and the GPU rect buffer write port.

Parameters:
- DATA_WIDTH, 16, data memory and rect buffer word width.
- ADDR_WIDTH, 13, data memory address width.
- RECT_COUNT, 64, rectangles copied per frame.
- RECT_WORDS, 5, words per rectangle (x, y, w, h, color).
- RECT_BASE, 13'h1000, data memory address of rect 0 word 0.
- BUF_ADDR_WIDTH, 9, rect buffer address width; must satisfy 2^BUF_ADDR_WIDTH >= RECT_COUNT*RECT_WORDS.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- copy_start  in  1  one-cycle start pulse
- copy  in  1  copy-ownership flag; level-held for the whole copy window
- mem_addr  out  ADDR_WIDTH  data memory read address
- mem_rd_en  out  1  data memory read enable
- mem_rd_data  in  DATA_WIDTH  read data, valid exactly one cycle after mem_rd_en
- buf_wr_en  out  1  rect buffer write strobe
- buf_wr_addr  out  BUF_ADDR_WIDTH  rect buffer word address
- buf_wr_data  out  DATA_WIDTH  rect buffer write data
- busy  out  1  high from the first READ cycle through the DRAIN cycle
- done  out  1  one-cycle pulse after the final buffer write

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Total words: N = RECT_COUNT*RECT_WORDS (320 by default).
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - `copy_start && copy` -> READ with read index i=0.
  - `copy_start` while `!copy` is ignored.
- READ, each cycle:
  - mem_rd_en=1, mem_addr=RECT_BASE+i, i increments.
  - When i==N-1 is issued -> DRAIN.
- Write pipeline:
  - A registered delayed read-valid and write index drive the buffer port.
  - The cycle after each read: buf_wr_en=1, buf_wr_addr=write index, buf_wr_data=mem_rd_data.
- DRAIN: the final write occurs; next state DONE.
- DONE: done=1 for one cycle; next state IDLE.
- Latency:
  - First write 2 cycles after copy_start (1 cycle to enter READ, 1 cycle memory latency).
  - done asserted N+2 cycles after the copy_start cycle.
- busy: 1 in READ and DRAIN only.
- mem_addr arithmetic is modulo 2^ADDR_WIDTH; wrap past the top of memory is permitted and not flagged.
- Abort: if `copy` falls in READ or DRAIN:
  - Go to IDLE next cycle.
  - mem_rd_en and buf_wr_en are forced 0 in that same cycle, including any pending delayed write.
  - No done pulse.
  - The buffer keeps the partial contents.
- copy_start while busy or in DONE is ignored; no restart.
- copy_start and a falling `copy` in the same IDLE cycle: the start is ignored.
- Reset mid-operation returns to IDLE immediately; no further writes.

Optional Feature:
- Macro: RECT_COPY_CHECKSUM_EN.
- When defined:
  - Adds output port `checksum` (out, DATA_WIDTH).
  - A running modulo-2^DATA_WIDTH sum of every written word, cleared on the copy_start that is accepted.
  - `checksum` is registered and updated to the final sum in the DONE cycle; it holds until the next accepted start.
  - Reset value 0. Abort leaves the previous value unchanged.
- When undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package brus16_pkg holds:
  - Default RECT_COUNT, RECT_WORDS, RECT_BASE and the width constants, alongside constants.svh.
  - The `copy_state_t` enum {IDLE, READ, DRAIN, DONE}.
- One natural sub-module, copy_addr_counter:
  - Loadable, enable-gated counter with a terminal-count flag.
  - Instanced twice: read index and write index.

Test Plan:
- Nominal copy:
  - Preload mem[0x1000+k]=k^16'hA5A5 for k<320, copy=1, pulse copy_start.
  - Expect 320 writes with buf[k]=k^16'hA5A5, first write at cycle +2, done exactly at cycle +322, busy low afterwards.
- Start without ownership: copy_start with copy=0 -> no mem_rd_en, no writes, no done.
- Abort mid-copy:
  - Drop copy at cycle +100.
  - Expect no buf_wr_en from that cycle on, no done, state IDLE.
  - A fresh start re-copies all 320 words from index 0.
- Restart ignored: second copy_start at cycle +50 -> address sequence continues monotonically; done occurs once at +322.
- Wrap:
  - RECT_BASE=13'h1FFE, RECT_COUNT=1.
  - Expect mem_addr sequence 1FFE, 1FFF, 0000, 0001, 0002.
- Checksum (RECT_COPY_CHECKSUM_EN):
  - All words 16'h0001 -> checksum=16'd320 at DONE.
  - All words 16'hFFFF -> checksum=16'hFEC0.
